rsa_job_sequencer: RTL and testbench
====================================

RSA_JOB_SEQUENCER -- requirements
Module: rsa_job_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand/result width in bits.
REQ-002 SHALL have parameter TIMEOUT, default 1023, maximum RUN cycles before the job is failed; timer width is $clog2(TIMEOUT+1).
REQ-003 SHALL have clk  input  1  single clock; all state changes on posedge.
REQ-004 SHALL have rstb  input  1  asynchronous active-low reset.
REQ-005 SHALL have ena  input  1  global clock enable; when 0, every register holds its value.
REQ-006 SHALL have req_valid  input  1 and req_ready  output  1, forming the job request handshake.
REQ-007 SHALL have req_m, req_e, req_n  input  WIDTH each, giving the job operands: message, exponent and modulus.
REQ-008 SHALL have core_m, core_e, core_n  output  WIDTH each, the latched operands driven to the exponentiation core.
REQ-009 SHALL have core_clear  output  1, the core clear; 0 holds the core FSM in reset and 1 lets it run.
REQ-010 SHALL have core_ena  output  1, equal to ena.
REQ-011 SHALL have core_eoc  input  1, the end-of-computation flag from the core; it is level and sticky.
REQ-012 SHALL have core_result  input  WIDTH, the core result, valid while core_eoc=1.
REQ-013 SHALL have rsp_valid  output  1 and rsp_ready  input  1, forming the response handshake.
REQ-014 SHALL have rsp_data  output  WIDTH (result) and rsp_err  output  1 (timeout flag), both registered.
REQ-015 SHALL have busy  output  1, which is 1 in every state other than IDLE.
REQ-016 SHALL have job_count  output  8, counting completed responses, with wrap-around.

Function
REQ-017 SHALL implement the states IDLE, CLR, RUN and RESP; a transition occurs only on a clk edge with ena=1.
REQ-018 SHALL decode outputs from state:
- req_ready=1 only in IDLE.
- rsp_valid=1 only in RESP.
- core_clear=1 only in RUN.
REQ-019 IDLE: when req_valid=1, SHALL latch req_m/e/n into core_m/e/n, clear the timer and CLR counter, and go to CLR.
REQ-020 CLR: SHALL hold core_clear=0 for exactly 2 cycles, counted by the CLR counter, then go to RUN; this flushes stale core_eoc.
REQ-021 RUN: SHALL increment the timer every enabled cycle.
REQ-022 RUN: on core_eoc=1, SHALL load rsp_data=core_result and rsp_err=0, then go to RESP.
REQ-023 RUN: when the timer equals TIMEOUT with core_eoc=0, SHALL load rsp_data=0 and rsp_err=1, then go to RESP.
REQ-024 SHALL give core_eoc priority if core_eoc=1 and timer==TIMEOUT occur in the same cycle.
REQ-025 RESP: SHALL hold rsp_valid, rsp_data and rsp_err stable until rsp_ready=1, then increment job_count and go to IDLE.
REQ-026 SHALL accept no new request before the response handshake completes; there is no pipelining and no queue.
REQ-027 SHALL fix latency: request accepted at edge k, core_clear rises after edge k+2, and the first RUN cycle is k+2..k+3.
REQ-028 SHALL freeze everything while ena=0: state, timer, CLR counter, operands, response registers and job_count.
REQ-029 SHALL ignore core_eoc outside RUN.
REQ-030 SHALL ignore req_valid outside IDLE.
REQ-031 Any unused state encoding SHALL return to IDLE on the next enabled edge.
REQ-032 job_count SHALL wrap from 255 to 0.

Reset
REQ-033 While rstb=0 the block SHALL be in state IDLE with req_ready=1, rsp_valid=0 and busy=0.
REQ-034 While rstb=0 SHALL hold core_clear=0, core_m/e/n=0, rsp_data=0, rsp_err=0, job_count=0, timer=0 and CLR counter=0.
REQ-035 Reset asserted mid-job SHALL abandon the job immediately and asynchronously, with no response issued.

Verification
REQ-036 Nominal (WIDTH=8): req m=0x05, e=0x03, n=0x77; core model raises eoc 114 cycles after core_clear rises, with result 0x2A.
- Required: rsp_valid=1 the next cycle, rsp_data=0x2A, rsp_err=0, job_count=1.
REQ-037 Timeout (TIMEOUT=20, core_eoc held 0): rsp_err=1 and rsp_data=0 in RESP, entered after 21 RUN cycles; core_clear=0 in RESP.
REQ-038 Backpressure: hold rsp_ready=0 for 5 cycles while asserting a second req_valid.
- Required: rsp_valid and data stable, req_ready=0, and the second job is accepted only after the handshake.
REQ-039 Stale eoc: core_eoc stuck 1 at request time.
- Required: no response during CLR; response taken on the first RUN cycle.
REQ-040 ena=0 for 10 cycles mid-RUN: the timer and state hold.
- Required: TIMEOUT=20 fires exactly 10 cycles later than without the stall.
REQ-041 rstb pulsed low mid-RUN, and simultaneous eoc with timeout.
- Reset: all outputs return to the REQ-033/REQ-034 values with no response.
- Simultaneous eoc/timeout: rsp_err=0 and rsp_data=core_result.

Source files
------------

// File: rtl/rsa_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : rsa_job_sequencer
//  Purpose  : Single-job sequencer in front of a modular-exponentiation core.
//             Accepts one request, flushes the core for two cycles, lets it
//             run until end-of-computation or timeout, then holds a registered
//             response until it is taken. No pipelining and no queue.
//  Revision : 1.0 - initial release
// ============================================================================
module rsa_job_sequencer #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic             clk,
    input  logic             rstb,
    input  logic             ena,

    input  logic             req_valid,
    output logic             req_ready,
    input  logic [WIDTH-1:0] req_m,
    input  logic [WIDTH-1:0] req_e,
    input  logic [WIDTH-1:0] req_n,

    output logic [WIDTH-1:0] core_m,
    output logic [WIDTH-1:0] core_e,
    output logic [WIDTH-1:0] core_n,
    output logic             core_clear,
    output logic             core_ena,
    input  logic             core_eoc,
    input  logic [WIDTH-1:0] core_result,

    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_err,

    output logic             busy,
    output logic [7:0]       job_count
);

    // Timer must be able to hold the value TIMEOUT itself.
    localparam int             TW          = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0]  TIMEOUT_VAL = TW'(TIMEOUT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t        state;
    logic [TW-1:0] timer;
    // Two CLR cycles need only one bit: 0 = first cycle, 1 = second cycle.
    logic          clr_cnt;

    // The core shares the global enable so both sides freeze together.
    assign core_ena = ena;

    // Sequencer FSM: state, operand latch, timer, response and handshake
    // outputs are all registered here and only move on an enabled edge.
    always_ff @(posedge clk or negedge rstb) begin
        if (!rstb) begin
            state      <= IDLE;
            req_ready  <= 1'b1;
            rsp_valid  <= 1'b0;
            core_clear <= 1'b0;
            busy       <= 1'b0;
            core_m     <= '0;
            core_e     <= '0;
            core_n     <= '0;
            rsp_data   <= '0;
            rsp_err    <= 1'b0;
            job_count  <= 8'd0;
            timer      <= '0;
            clr_cnt    <= 1'b0;
        end else if (ena) begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        core_m    <= req_m;
                        core_e    <= req_e;
                        core_n    <= req_n;
                        timer     <= '0;
                        clr_cnt   <= 1'b0;
                        state     <= CLR;
                        req_ready <= 1'b0;
                        busy      <= 1'b1;
                    end
                end

                // Core held in clear so any eoc left from a prior job drops.
                CLR: begin
                    if (clr_cnt) begin
                        state      <= RUN;
                        core_clear <= 1'b1;
                    end else begin
                        clr_cnt <= 1'b1;
                    end
                end

                // eoc is tested first so it wins over a coincident timeout.
                RUN: begin
                    timer <= timer + 1'b1;
                    if (core_eoc) begin
                        rsp_data   <= core_result;
                        rsp_err    <= 1'b0;
                        state      <= RESP;
                        core_clear <= 1'b0;
                        rsp_valid  <= 1'b1;
                    end else if (timer == TIMEOUT_VAL) begin
                        rsp_data   <= '0;
                        rsp_err    <= 1'b1;
                        state      <= RESP;
                        core_clear <= 1'b0;
                        rsp_valid  <= 1'b1;
                    end
                end

                // Response registers are untouched here, so they stay stable
                // for as long as the consumer applies backpressure.
                RESP: begin
                    if (rsp_ready) begin
                        job_count <= job_count + 8'd1;
                        state     <= IDLE;
                        rsp_valid <= 1'b0;
                        req_ready <= 1'b1;
                        busy      <= 1'b0;
                    end
                end

                default: begin
                    state      <= IDLE;
                    req_ready  <= 1'b1;
                    rsp_valid  <= 1'b0;
                    core_clear <= 1'b0;
                    busy       <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rsa_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rsa_job_sequencer
//  Purpose  : Directed bench. Instance A uses the default TIMEOUT for the
//             nominal, stale-eoc, backpressure and wrap cases; instance B uses
//             TIMEOUT=20 for timeout, stall, coincidence and reset cases.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_rsa_job_sequencer;

    logic       clk = 1'b0;
    logic       rstb;
    logic       ena;
    logic [7:0] req_m, req_e, req_n;
    logic       rsp_ready;

    logic       a_req_valid, a_core_eoc;
    logic [7:0] a_core_result;
    logic       a_req_ready, a_core_clear, a_core_ena, a_rsp_valid, a_rsp_err, a_busy;
    logic [7:0] a_core_m, a_core_e, a_core_n, a_rsp_data, a_job_count;

    logic       b_req_valid, b_core_eoc;
    logic [7:0] b_core_result;
    logic       b_req_ready, b_core_clear, b_core_ena, b_rsp_valid, b_rsp_err, b_busy;
    logic [7:0] b_core_m, b_core_e, b_core_n, b_rsp_data, b_job_count;

    int tests  = 0;
    int failed = 0;

    rsa_job_sequencer #(.WIDTH(8), .TIMEOUT(1023)) dut_a (
        .clk(clk), .rstb(rstb), .ena(ena),
        .req_valid(a_req_valid), .req_ready(a_req_ready),
        .req_m(req_m), .req_e(req_e), .req_n(req_n),
        .core_m(a_core_m), .core_e(a_core_e), .core_n(a_core_n),
        .core_clear(a_core_clear), .core_ena(a_core_ena),
        .core_eoc(a_core_eoc), .core_result(a_core_result),
        .rsp_valid(a_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .busy(a_busy), .job_count(a_job_count)
    );

    rsa_job_sequencer #(.WIDTH(8), .TIMEOUT(20)) dut_b (
        .clk(clk), .rstb(rstb), .ena(ena),
        .req_valid(b_req_valid), .req_ready(b_req_ready),
        .req_m(req_m), .req_e(req_e), .req_n(req_n),
        .core_m(b_core_m), .core_e(b_core_e), .core_n(b_core_n),
        .core_clear(b_core_clear), .core_ena(b_core_ena),
        .core_eoc(b_core_eoc), .core_result(b_core_result),
        .rsp_valid(b_rsp_valid), .rsp_ready(rsp_ready),
        .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .busy(b_busy), .job_count(b_job_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_byte(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rstb = 1'b0; ena = 1'b1; rsp_ready = 1'b0;
        req_m = 8'h00; req_e = 8'h00; req_n = 8'h00;
        a_req_valid = 1'b0; a_core_eoc = 1'b0; a_core_result = 8'h00;
        b_req_valid = 1'b0; b_core_eoc = 1'b0; b_core_result = 8'h00;

        // ---------------- reset values ----------------
        steps(3);
        check_bit ("rst_req_ready",  a_req_ready,  1'b1);
        check_bit ("rst_rsp_valid",  a_rsp_valid,  1'b0);
        check_bit ("rst_busy",       a_busy,       1'b0);
        check_bit ("rst_core_clear", a_core_clear, 1'b0);
        check_byte("rst_core_m",     a_core_m,     8'h00);
        check_byte("rst_rsp_data",   a_rsp_data,   8'h00);
        check_bit ("rst_rsp_err",    a_rsp_err,    1'b0);
        check_byte("rst_job_count",  a_job_count,  8'h00);
        rstb = 1'b1;
        step();

        // ---------------- nominal job on A ----------------
        req_m = 8'h05; req_e = 8'h03; req_n = 8'h77; a_req_valid = 1'b1;
        step();                                   // edge k: accepted
        a_req_valid = 1'b0;
        check_bit ("nom_busy",       a_busy,       1'b1);
        check_bit ("nom_req_ready",  a_req_ready,  1'b0);
        check_byte("nom_core_m",     a_core_m,     8'h05);
        check_byte("nom_core_e",     a_core_e,     8'h03);
        check_byte("nom_core_n",     a_core_n,     8'h77);
        check_bit ("nom_clr_k",      a_core_clear, 1'b0);
        step();                                   // edge k+1
        check_bit ("nom_clr_k1",     a_core_clear, 1'b0);
        step();                                   // edge k+2: RUN
        check_bit ("nom_clr_k2",     a_core_clear, 1'b1);
        steps(114);
        check_bit ("nom_no_rsp_yet", a_rsp_valid,  1'b0);
        a_core_eoc = 1'b1; a_core_result = 8'h2A;
        step();
        check_bit ("nom_rsp_valid",  a_rsp_valid,  1'b1);
        check_byte("nom_rsp_data",   a_rsp_data,   8'h2A);
        check_bit ("nom_rsp_err",    a_rsp_err,    1'b0);
        check_bit ("nom_clr_resp",   a_core_clear, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_byte("nom_job_count",  a_job_count,  8'd1);
        check_bit ("nom_idle_ready", a_req_ready,  1'b1);
        check_bit ("nom_idle_valid", a_rsp_valid,  1'b0);

        // ---------------- stale eoc on A (eoc still 1) ----------------
        req_m = 8'h11; a_core_result = 8'h3C; a_req_valid = 1'b1;
        step();                                   // k
        a_req_valid = 1'b0;
        check_bit ("stale_clr0_valid", a_rsp_valid, 1'b0);
        step();                                   // k+1
        check_bit ("stale_clr1_valid", a_rsp_valid, 1'b0);
        step();                                   // k+2: RUN
        check_bit ("stale_run_valid",  a_rsp_valid, 1'b0);
        check_bit ("stale_run_clear",  a_core_clear, 1'b1);
        step();                                   // k+3: eoc taken
        check_bit ("stale_rsp_valid",  a_rsp_valid, 1'b1);
        check_byte("stale_rsp_data",   a_rsp_data,  8'h3C);

        // ---------------- backpressure on A ----------------
        req_m = 8'h99; a_req_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            check_bit ("bp_valid",     a_rsp_valid, 1'b1);
            check_byte("bp_data",      a_rsp_data,  8'h3C);
            check_bit ("bp_req_ready", a_req_ready, 1'b0);
            check_byte("bp_core_m",    a_core_m,    8'h11);
        end
        rsp_ready = 1'b1;
        step();                                   // handshake
        rsp_ready = 1'b0;
        check_byte("bp_job_count", a_job_count, 8'd2);
        check_bit ("bp_ready_now", a_req_ready, 1'b1);
        check_byte("bp_core_m_hold", a_core_m,  8'h11);
        step();                                   // second job accepted
        a_req_valid = 1'b0;
        check_byte("bp_core_m_new", a_core_m,   8'h99);
        check_bit ("bp_busy2",      a_busy,     1'b1);
        steps(3);
        check_bit ("bp_rsp2_valid", a_rsp_valid, 1'b1);
        rsp_ready = 1'b1;
        step();
        check_byte("bp_job_count3", a_job_count, 8'd3);

        // ---------------- job_count wrap on A ----------------
        a_req_valid = 1'b1;                       // 5 edges per job
        steps(5 * 252);
        check_byte("wrap_255", a_job_count, 8'd255);
        steps(5);
        a_req_valid = 1'b0;
        rsp_ready   = 1'b0;
        check_byte("wrap_0",   a_job_count, 8'd0);
        a_core_eoc  = 1'b0;
        step();

        // ---------------- timeout on B ----------------
        b_req_valid = 1'b1;
        step();
        b_req_valid = 1'b0;
        steps(2);                                 // now in RUN, timer=0
        check_bit ("to_run_clear", b_core_clear, 1'b1);
        steps(20);
        check_bit ("to_not_yet",   b_rsp_valid,  1'b0);
        step();                                   // 21st RUN edge
        check_bit ("to_valid",     b_rsp_valid,  1'b1);
        check_bit ("to_err",       b_rsp_err,    1'b1);
        check_byte("to_data",      b_rsp_data,   8'h00);
        check_bit ("to_clear",     b_core_clear, 1'b0);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_byte("to_job_count", b_job_count,  8'd1);

        // ---------------- ena stall mid-RUN on B ----------------
        b_req_valid = 1'b1;
        step();
        b_req_valid = 1'b0;
        steps(2);
        steps(5);                                 // 5 RUN edges taken
        ena = 1'b0;
        check_bit ("stall_core_ena", b_core_ena, 1'b0);
        steps(10);
        check_bit ("stall_clear",    b_core_clear, 1'b1);
        check_bit ("stall_valid",    b_rsp_valid,  1'b0);
        ena = 1'b1;
        steps(15);
        check_bit ("stall_not_yet",  b_rsp_valid,  1'b0);
        step();                                   // 21st enabled RUN edge
        check_bit ("stall_valid_to", b_rsp_valid,  1'b1);
        check_bit ("stall_err",      b_rsp_err,    1'b1);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        check_byte("stall_job_count", b_job_count, 8'd2);

        // ---------------- simultaneous eoc and timeout on B ----------------
        b_req_valid = 1'b1;
        step();
        b_req_valid = 1'b0;
        steps(2);
        steps(20);                                // timer == 20 now
        b_core_eoc = 1'b1; b_core_result = 8'h5A;
        step();
        check_bit ("sim_valid", b_rsp_valid, 1'b1);
        check_bit ("sim_err",   b_rsp_err,   1'b0);
        check_byte("sim_data",  b_rsp_data,  8'h5A);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        b_core_eoc = 1'b0;
        check_byte("sim_job_count", b_job_count, 8'd3);

        // ---------------- reset mid-RUN on B ----------------
        req_m = 8'h33; b_req_valid = 1'b1;
        step();
        b_req_valid = 1'b0;
        steps(5);
        check_bit ("mr_pre_clear", b_core_clear, 1'b1);
        rstb = 1'b0;
        #1;                                       // asynchronous, no edge
        check_bit ("mr_busy",      b_busy,       1'b0);
        check_bit ("mr_req_ready", b_req_ready,  1'b1);
        check_bit ("mr_clear",     b_core_clear, 1'b0);
        check_byte("mr_core_m",    b_core_m,     8'h00);
        check_bit ("mr_valid",     b_rsp_valid,  1'b0);
        check_byte("mr_rsp_data",  b_rsp_data,   8'h00);
        check_bit ("mr_err",       b_rsp_err,    1'b0);
        check_byte("mr_job_count", b_job_count,  8'h00);
        step();
        rstb = 1'b1;
        b_core_eoc = 1'b1;
        steps(4);
        check_bit ("mr_no_rsp",    b_rsp_valid,  1'b0);
        check_bit ("mr_idle",      b_busy,       1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
